// File: rtl/div_seq.sv
// div_seq -- multi-cycle radix-2 restoring integer divider (DIV / DIVU).
//
// Computes quotient and remainder of opdata1 / opdata2. A nonzero-divisor
// operation takes WIDTH iterations plus one finishing edge. Divide-by-zero
// finishes on the edge after acceptance.
//
// Handshake: the requester raises div_start with operands and div_signed
// valid and holds them until it sees div_ready. Operands are sampled once,
// on the accepting edge in IDLE. div_result is valid exactly while
// div_ready=1. Both stay asserted while div_start stays high. Dropping
// div_start returns the unit to IDLE on the next edge, clearing both.
// div_annul (a pipeline flush) overrides everything and never yields a
// ready pulse.
//
// Ports:
//   clk         pipeline clock
//   rst         asynchronous, active-low reset
//   div_start   operation request (held until div_ready)
//   div_signed  1 = signed DIV, 0 = unsigned DIVU (sampled with div_start)
//   div_annul   abort current operation
//   opdata1     dividend (sampled with div_start)
//   opdata2     divisor  (sampled with div_start)
//   div_result  {remainder, quotient}
//   div_ready   operation complete (registered)
//   dbg_state   current FSM state (IDLE=0, DIVZERO=1, ON=2, END=3)
//
// Build option: define DIV_EARLY_OUT_EN to finish early when
// |dividend| < |divisor|. Results are identical with or without it.

module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 div_start,
  input  logic                 div_signed,
  input  logic                 div_annul,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  output logic [2*WIDTH-1:0]   div_result,
  output logic                 div_ready,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_DONE = CW'(WIDTH);

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     dvd_q, dvd_d;   // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0]     dvs_q, dvs_d;   // |divisor|
  logic [WIDTH-1:0]     rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0]     op1_q, op1_d;   // original dividend, for divide-by-zero
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 ready_d;
  logic [2*WIDTH-1:0]   result_d;

  logic [WIDTH-1:0]     abs1, abs2;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     quo_fin, rem_fin;
  logic                 early_out;

  assign abs1 = (div_signed && opdata1[WIDTH-1]) ? (~opdata1 + ONE) : opdata1;
  assign abs2 = (div_signed && opdata2[WIDTH-1]) ? (~opdata2 + ONE) : opdata2;

  // Shift in the next dividend bit, then trial-subtract; trial[WIDTH] is the borrow.
  assign trial   = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
  assign quo_fin = neg_quo_q ? (~dvd_q + ONE) : dvd_q;
  assign rem_fin = neg_rem_q ? (~rem_q + ONE) : rem_q;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (abs1 < abs2);
`else
  assign early_out = 1'b0;
`endif

  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    op1_d     = op1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = div_ready;
    result_d  = div_result;

    case (state_q)
      S_IDLE: begin
        ready_d  = 1'b0;
        result_d = '0;
        cnt_d    = '0;
        if (div_start && !div_annul) begin
          op1_d     = opdata1;
          dvd_d     = abs1;
          dvs_d     = abs2;
          rem_d     = '0;
          neg_quo_d = div_signed & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
          neg_rem_d = div_signed & opdata1[WIDTH-1];
          if (opdata2 == '0) begin
            state_d = S_DIVZERO;
          end else if (early_out) begin
            // Quotient is 0 and remainder is |dividend|: preload the datapath
            // as if all iterations were done, so the next edge just applies signs.
            dvd_d   = '0;
            rem_d   = abs1;
            cnt_d   = CNT_DONE;
            state_d = S_ON;
          end else begin
            state_d = S_ON;
          end
        end
      end

      S_DIVZERO: begin
        if (div_annul) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {op1_q, {WIDTH{1'b1}}};
        end
      end

      S_ON: begin
        if (div_annul) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q == CNT_DONE) begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = {rem_fin, quo_fin};
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
          end
        end
      end

      S_END: begin
        if (div_annul || !div_start) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      op1_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_ready  <= 1'b0;
      div_result <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      op1_q      <= op1_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_ready  <= ready_d;
      div_result <= result_d;
    end
  end

endmodule
